vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_cell_sampler.sv | 62 ++++++
 rtl/vga_capture.sv | 126 ++++++++++++
 tb/tb_vga_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and timing defaults for the VGA board-capture block.
// 800x600 timing figures are the stock defaults for the capture path.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    WAIT_END = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  typedef struct packed {
    logic hit;
    logic fall;
  } samp_t;

  localparam int H_ACTIVE   = 800;
  localparam int H_SYNC_BEG = 856;
  localparam int H_SYNC_END = 976;
  localparam int H_TOTAL    = 1040;
  localparam int V_ACTIVE   = 600;
  localparam int V_SYNC_BEG = 637;
  localparam int V_SYNC_END = 643;
  localparam int V_TOTAL    = 666;

  function automatic int pixiv(
    input int hsize,
    input int n
  );
    return hsize / n;
  endfunction

  function automatic bit std_timing_ok();
    return (H_ACTIVE < H_SYNC_BEG) &&
           (H_SYNC_BEG < H_SYNC_END) &&
           (H_SYNC_END < H_TOTAL) &&
           (V_ACTIVE < V_SYNC_BEG) &&
           (V_SYNC_BEG < V_SYNC_END) &&
           (V_SYNC_END < V_TOTAL);
  endfunction

endpackage

// File: rtl/vga_cell_sampler.sv
// Pixel/line counters and board cell-centre detection.
// x is the index of the pixel currently on de; y the current line.
module vga_cell_sampler
  import vga_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int HSIZE     = 800,
  parameter int P_PARAM_N = 25,
  parameter int P_PARAM_M = 18,
  parameter int PIXIV     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               de,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output samp_t              samp,
  output logic [2*WIDTH-1:0] pos
);

  localparam logic [WIDTH-1:0] PIX  = WIDTH'(PIXIV);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(PIXIV / 2);
  localparam logic [WIDTH-1:0] HS   = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] ROWS = WIDTH'(P_PARAM_M);
  localparam logic [2*WIDTH-1:0] NCOL = (2*WIDTH)'(P_PARAM_N);

  logic             de_d;
  logic [WIDTH-1:0] col;
  logic [WIDTH-1:0] row;
  logic             centre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      de_d <= 1'b0;
    end else begin
      de_d <= de;
      if (!run) begin
        x <= '0;
        y <= '0;
      end else begin
        x <= de ? x + 1'b1 : '0;
        if (!de && de_d)
          y <= y + 1'b1;
      end
    end
  end

  always_comb begin
    col    = x / PIX;
    row    = y / PIX;
    centre = ((x % PIX) == HALF) && ((y % PIX) == HALF);
    pos    = (2*WIDTH)'(row) * NCOL + (2*WIDTH)'(col);
    samp      = '0;
    // guard on x keeps an overlong line from spilling into the next row
    samp.hit  = run && de && centre && (x < HS) && (row < ROWS);
    samp.fall = run && !de && de_d;
  end

endmodule

// File: rtl/vga_capture.sv
// Captures a cell board from VGA video: sync search FSM plus
// registered write/status outputs around the cell sampler.
module vga_capture
  import vga_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int HSIZE     = H_ACTIVE,
  parameter int VSIZE     = V_ACTIVE,
  parameter int P_PARAM_N = 25,
  parameter int P_PARAM_M = 18,
  parameter int VSPP      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               data_enable,
  input  logic [7:0]         video_red,
  input  logic [7:0]         video_green,
  input  logic [7:0]         video_blue,
  output logic               wr_en,
  output logic [2*WIDTH-1:0] wr_pos,
  output logic               wr_live,
  output logic               frame_done,
  output logic               frame_err,
  output logic               locked
);

  localparam int PIXIV = pixiv(HSIZE, P_PARAM_N);
  localparam logic VPOL = 1'(VSPP);
  localparam logic [WIDTH-1:0] HS      = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] VS_LAST = WIDTH'(VSIZE - 1);

  state_t             state, state_n;
  logic               vs_q, vs_d, de_q, live_q;
  logic               vs_act, vs_end;
  logic               done_n, err_n, hit_ok;
  logic [WIDTH-1:0]   x, y;
  logic [2*WIDTH-1:0] pos;
  samp_t              samp;
  logic               unused_in;

  assign unused_in = ^{hsync, video_red[6:0],
                       video_green[6:0], video_blue[6:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      vs_d   <= 1'b0;
      de_q   <= 1'b0;
      live_q <= 1'b0;
    end else begin
      vs_q   <= vsync;
      vs_d   <= vs_q;
      de_q   <= data_enable;
      live_q <= video_red[7] & video_green[7] & video_blue[7];
    end
  end

  assign vs_act = (vs_q == VPOL);
  // WAIT_END leaves only on the trailing edge of a sync pulse
  assign vs_end = (vs_d == VPOL) && !vs_act;

  vga_cell_sampler #(
    .WIDTH     (WIDTH),
    .HSIZE     (HSIZE),
    .P_PARAM_N (P_PARAM_N),
    .P_PARAM_M (P_PARAM_M),
    .PIXIV     (PIXIV)
  ) u_sampler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state == CAPTURE),
    .de    (de_q),
    .x     (x),
    .y     (y),
    .samp  (samp),
    .pos   (pos)
  );

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      SEARCH:   if (vs_act) state_n = WAIT_END;
      WAIT_END: if (vs_end) state_n = CAPTURE;
      CAPTURE: begin
        if (samp.fall && (x != HS)) begin
          err_n   = 1'b1;
          state_n = SEARCH;
        end else if (samp.fall && (y == VS_LAST)) begin
          done_n  = 1'b1;
          state_n = WAIT_END;
        end else if (vs_act) begin
          err_n   = 1'b1;
          state_n = WAIT_END;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  assign hit_ok = samp.hit && (state_n == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      wr_en      <= 1'b0;
      wr_pos     <= '0;
      wr_live    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      wr_en      <= hit_ok;
      wr_pos     <= hit_ok ? pos : '0;
      wr_live    <= hit_ok & live_q;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  assign locked = (state == CAPTURE);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on an 8x4 frame, 4x2 board.
// Writes and pulses are logged on negedge and compared per scenario.
module tb_vga_capture;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hsync = 1'b0;
  logic         vsync = 1'b0;
  logic         data_enable = 1'b0;
  logic [7:0]   video_red = '0;
  logic [7:0]   video_green = '0;
  logic [7:0]   video_blue = '0;
  logic         wr_en;
  logic [2*W-1:0] wr_pos;
  logic         wr_live;
  logic         frame_done;
  logic         frame_err;
  logic         locked;

  vga_capture #(
    .WIDTH     (W),
    .HSIZE     (8),
    .VSIZE     (4),
    .P_PARAM_N (4),
    .P_PARAM_M (2),
    .VSPP      (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .data_enable (data_enable),
    .video_red   (video_red),
    .video_green (video_green),
    .video_blue  (video_blue),
    .wr_en       (wr_en),
    .wr_pos      (wr_pos),
    .wr_live     (wr_live),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int pat = 0;
  int rst_x = -1;
  int rst_y = -1;
  int pix_cyc = -1;
  int n_done = 0;
  int n_err = 0;
  int n_bad = 0;
  int q_pos[$];
  int q_live[$];
  int q_cyc[$];

  always @(negedge clk) begin
    if (wr_en) begin
      q_pos.push_back(int'(wr_pos));
      q_live.push_back(int'(wr_live));
      q_cyc.push_back(cyc);
      if (!locked) n_bad <= n_bad + 1;
    end
    if (frame_done) n_done <= n_done + 1;
    if (frame_err) n_err <= n_err + 1;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rgb(input int x, input int y);
    case (pat)
      0: return 24'hFFFFFF;
      1: return (x / 2 == 2 && y / 2 == 1) ? 24'hFFFFFF : 24'h0;
      3: begin
        if (x == 1 && y == 1) return 24'h80807F;
        if (x == 3 && y == 1) return 24'h808080;
        return 24'h0;
      end
      default: return 24'h0;
    endcase
  endfunction

  task automatic send_frame(
    input int nlines,
    input int short_y,
    input int short_len
  );
    vsync = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (2) tick();
    for (int y = 0; y < nlines; y++) begin
      int len;
      len = (y == short_y) ? short_len : 8;
      for (int x = 0; x < len; x++) begin
        if (x == rst_x && y == rst_y) begin
          check("pre_rst_locked", 32'(locked), 1);
          rst_n = 1'b0;
          #1;
          check("rst_wr_en", 32'(wr_en), 0);
          check("rst_wr_pos", 32'(wr_pos), 0);
          check("rst_wr_live", 32'(wr_live), 0);
          check("rst_locked", 32'(locked), 0);
          check("rst_err", 32'(frame_err), 0);
        end
        data_enable = 1'b1;
        {video_red, video_green, video_blue} = rgb(x, y);
        if (pat == 1 && x == 5 && y == 3) pix_cyc = cyc;
        tick();
        if (!rst_n) rst_n = 1'b1;
      end
      data_enable = 1'b0;
      {video_red, video_green, video_blue} = 24'h0;
      hsync = 1'b1;
      tick();
      hsync = 1'b0;
      repeat (2) tick();
    end
    repeat (3) tick();
  endtask

  task automatic expect_frame(
    input string      tag,
    input int         b,
    input logic [7:0] live
  );
    for (int i = 0; i < 8; i++) begin
      int p;
      int l;
      p = -1;
      l = -1;
      if (b + i < q_pos.size()) begin
        p = q_pos[b + i];
        l = q_live[b + i];
      end
      check({tag, "_pos"}, p, i);
      check({tag, "_live"}, l, 32'(live[i]));
    end
  endtask

  initial begin
    int b;
    int d;
    int e;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    check("reset_wr_en", 32'(wr_en), 0);
    check("reset_wr_pos", 32'(wr_pos), 0);
    check("reset_done", 32'(frame_done), 0);
    check("reset_err", 32'(frame_err), 0);
    check("reset_locked", 32'(locked), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    b = q_pos.size(); d = n_done; e = n_err;
    pat = 0;
    send_frame(4, -1, 0);
    check("white_writes", q_pos.size() - b, 8);
    expect_frame("white", b, 8'hFF);
    check("white_done", n_done - d, 1);
    check("white_err", n_err - e, 0);

    b = q_pos.size(); d = n_done;
    pat = 1;
    send_frame(4, -1, 0);
    check("chk_writes", q_pos.size() - b, 8);
    expect_frame("chk", b, 8'b0100_0000);
    check("chk_done", n_done - d, 1);
    lat = -1;
    for (int i = b; i < q_pos.size(); i++)
      if (q_pos[i] == 6) lat = q_cyc[i] - pix_cyc;
    check("chk_latency", lat, 2);

    b = q_pos.size(); d = n_done; e = n_err;
    pat = 0;
    send_frame(4, 2, 7);
    check("short_locked", 32'(locked), 0);
    check("short_err", n_err - e, 1);
    check("short_done", n_done - d, 0);
    check("short_writes", q_pos.size() - b, 4);
    b = q_pos.size(); d = n_done;
    send_frame(4, -1, 0);
    check("short_next_writes", q_pos.size() - b, 8);
    check("short_next_done", n_done - d, 1);

    b = q_pos.size(); d = n_done; e = n_err;
    send_frame(3, -1, 0);
    send_frame(4, -1, 0);
    check("early_vs_err", n_err - e, 1);
    check("early_vs_done", n_done - d, 1);
    check("early_vs_writes", q_pos.size() - b, 12);

    b = q_pos.size(); d = n_done; e = n_err;
    rst_x = 4; rst_y = 1;
    send_frame(4, -1, 0);
    rst_x = -1; rst_y = -1;
    check("rst_frame_writes", q_pos.size() - b, 1);
    check("rst_frame_err", n_err - e, 0);
    check("rst_frame_done", n_done - d, 0);
    b = q_pos.size(); d = n_done;
    send_frame(4, -1, 0);
    check("rst_next_writes", q_pos.size() - b, 8);
    check("rst_next_done", n_done - d, 1);

    b = q_pos.size();
    pat = 3;
    send_frame(4, -1, 0);
    expect_frame("msb", b, 8'b0000_0010);

    check("wr_en_unlocked", n_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles want finish", cyc);
    $fatal(1);
  end

endmodule
